// File: rtl/pipeline_pkg.sv
// Shared definitions for the 32-bit MIPS pipeline stage registers.
package pipeline_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;

   // Write-back control bits carried through the MEM/WB register.
   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } memwb_ctrl_t;

   localparam int unsigned MEMWB_CTRL_W = $bits(memwb_ctrl_t);

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterised pipeline register: async active-low reset, flush clears, stall holds.
module pipe_reg #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic         flush,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Flush outranks stall so a bubble can be injected into a frozen stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (flush)
         q <= '0;
      else if (!stall)
         q <= d;
   end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register; define MEM_WB_WB_MUX_EN to add the write-back data mux output wb_data_out.
module mem_wb
   import pipeline_pkg::*;
#(
   parameter int unsigned n = DATA_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  Reg_Write_in,
   input  logic                  MemtoReg_in,
   input  logic [n-1:0]          data_memory_output_in,
   input  logic [n-1:0]          ALU_Output_in,
   input  logic [REG_ADDR_W-1:0] EX_MEM_Rd_in,
   output logic                  Reg_Write_out,
   output logic                  MemtoReg_out,
   output logic [n-1:0]          data_memory_output_out,
   output logic [n-1:0]          ALU_Output_to_MUX_out,
   output logic [REG_ADDR_W-1:0] MEM_WB_Rd_out
`ifdef MEM_WB_WB_MUX_EN
   ,
   output logic [n-1:0]          wb_data_out
`endif
);

   memwb_ctrl_t ctrl_d;
   memwb_ctrl_t ctrl_q;

   assign ctrl_d.reg_write  = Reg_Write_in;
   assign ctrl_d.mem_to_reg = MemtoReg_in;

   pipe_reg #(.W(MEMWB_CTRL_W)) u_ctrl (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .flush (flush),
      .d     (ctrl_d),
      .q     (ctrl_q)
   );

   pipe_reg #(.W(n)) u_mem_data (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .flush (flush),
      .d     (data_memory_output_in),
      .q     (data_memory_output_out)
   );

   pipe_reg #(.W(n)) u_alu (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .flush (flush),
      .d     (ALU_Output_in),
      .q     (ALU_Output_to_MUX_out)
   );

   pipe_reg #(.W(REG_ADDR_W)) u_rd (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (stall),
      .flush (flush),
      .d     (EX_MEM_Rd_in),
      .q     (MEM_WB_Rd_out)
   );

   assign Reg_Write_out = ctrl_q.reg_write;
   assign MemtoReg_out  = ctrl_q.mem_to_reg;

`ifdef MEM_WB_WB_MUX_EN
   // Driven only from registered state, so no extra latency and no input-to-output path.
   assign wb_data_out = ctrl_q.mem_to_reg ? data_memory_output_out : ALU_Output_to_MUX_out;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for mem_wb; exercises wb_data_out when MEM_WB_WB_MUX_EN is defined.
module tb_mem_wb;

   localparam int unsigned N  = 32;
   localparam int unsigned VW = 2 + 2*N + 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         stall = 1'b0;
   logic         flush = 1'b0;
   logic         Reg_Write_in = 1'b0;
   logic         MemtoReg_in = 1'b0;
   logic [N-1:0] data_memory_output_in = '0;
   logic [N-1:0] ALU_Output_in = '0;
   logic [4:0]   EX_MEM_Rd_in = '0;
   logic         Reg_Write_out;
   logic         MemtoReg_out;
   logic [N-1:0] data_memory_output_out;
   logic [N-1:0] ALU_Output_to_MUX_out;
   logic [4:0]   MEM_WB_Rd_out;
`ifdef MEM_WB_WB_MUX_EN
   logic [N-1:0] wb_data_out;
`endif

   int checks = 0;
   int failures = 0;

   logic [VW-1:0] out_vec;
   assign out_vec = {Reg_Write_out, MemtoReg_out, data_memory_output_out,
                     ALU_Output_to_MUX_out, MEM_WB_Rd_out};

   mem_wb #(.n(N)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .stall                  (stall),
      .flush                  (flush),
      .Reg_Write_in           (Reg_Write_in),
      .MemtoReg_in            (MemtoReg_in),
      .data_memory_output_in  (data_memory_output_in),
      .ALU_Output_in          (ALU_Output_in),
      .EX_MEM_Rd_in           (EX_MEM_Rd_in),
      .Reg_Write_out          (Reg_Write_out),
      .MemtoReg_out           (MemtoReg_out),
      .data_memory_output_out (data_memory_output_out),
      .ALU_Output_to_MUX_out  (ALU_Output_to_MUX_out),
      .MEM_WB_Rd_out          (MEM_WB_Rd_out)
`ifdef MEM_WB_WB_MUX_EN
      ,
      .wb_data_out            (wb_data_out)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [VW-1:0] pack(input logic rw, input logic mtr,
                                          input logic [N-1:0] mem, input logic [N-1:0] alu,
                                          input logic [4:0] rd);
      return {rw, mtr, mem, alu, rd};
   endfunction

   task automatic drive(input logic rw, input logic mtr, input logic [N-1:0] mem,
                        input logic [N-1:0] alu, input logic [4:0] rd);
      Reg_Write_in          = rw;
      MemtoReg_in           = mtr;
      data_memory_output_in = mem;
      ALU_Output_in         = alu;
      EX_MEM_Rd_in          = rd;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [VW-1:0] exp;
      drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31);
      #2 rst_n = 1'b0;
      #1;
      exp = '0;
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL reset_immediate: got %h expected %h", out_vec, exp);
      end
      tick();
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL reset_held_over_edge: got %h expected %h", out_vec, exp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL reset_release_no_edge: got %h expected %h", out_vec, exp);
      end
   endtask

   task automatic test_basic_load;
      logic [VW-1:0] exp;
      drive(1'b1, 1'b1, 32'h0000_0007, 32'h0, 5'd0);
      tick();
      exp = pack(1'b1, 1'b1, 32'h0000_0007, 32'h0, 5'd0);
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL basic_load: got %h expected %h", out_vec, exp);
      end
   endtask

   task automatic test_pipelining;
      logic [VW-1:0] exp_a;
      logic [VW-1:0] exp_b;
      drive(1'b1, 1'b0, 32'h0000_0011, 32'hDEAD_BEEF, 5'd9);
      tick();
      exp_a = pack(1'b1, 1'b0, 32'h0000_0011, 32'hDEAD_BEEF, 5'd9);
      checks++;
      if (out_vec !== exp_a) begin
         failures++;
         $display("FAIL pipe_first: got %h expected %h", out_vec, exp_a);
      end
      drive(1'b0, 1'b1, 32'h0000_0022, 32'h1234_5678, 5'd3);
      #1;
      checks++;
      if (out_vec !== exp_a) begin
         failures++;
         $display("FAIL pipe_no_comb_path: got %h expected %h", out_vec, exp_a);
      end
      tick();
      exp_b = pack(1'b0, 1'b1, 32'h0000_0022, 32'h1234_5678, 5'd3);
      checks++;
      if (out_vec !== exp_b) begin
         failures++;
         $display("FAIL pipe_second: got %h expected %h", out_vec, exp_b);
      end
   endtask

   task automatic test_stall;
      logic [VW-1:0] held;
      logic [VW-1:0] exp;
      drive(1'b1, 1'b0, 32'hCAFE_0001, 32'h0BAD_F00D, 5'd17);
      tick();
      held = pack(1'b1, 1'b0, 32'hCAFE_0001, 32'h0BAD_F00D, 5'd17);
      stall = 1'b1;
      drive(1'b0, 1'b1, 32'h1111_2222, 32'h3333_4444, 5'd5);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_vec !== held) begin
            failures++;
            $display("FAIL stall_hold_%0d: got %h expected %h", i, out_vec, held);
         end
      end
      stall = 1'b0;
      tick();
      exp = pack(1'b0, 1'b1, 32'h1111_2222, 32'h3333_4444, 5'd5);
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL stall_release: got %h expected %h", out_vec, exp);
      end
   endtask

   task automatic test_flush;
      logic [VW-1:0] exp;
      stall = 1'b1;
      flush = 1'b1;
      drive(1'b1, 1'b1, 32'h8765_4321, 32'hFEDC_BA98, 5'd12);
      tick();
      exp = '0;
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL flush_over_stall: got %h expected %h", out_vec, exp);
      end
      stall = 1'b0;
      flush = 1'b0;
      tick();
      exp = pack(1'b1, 1'b1, 32'h8765_4321, 32'hFEDC_BA98, 5'd12);
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL reload_after_flush: got %h expected %h", out_vec, exp);
      end
      flush = 1'b1;
      tick();
      exp = '0;
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL flush_alone: got %h expected %h", out_vec, exp);
      end
      flush = 1'b0;
   endtask

   task automatic test_async_reset_mid;
      logic [VW-1:0] exp;
      drive(1'b1, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd21);
      tick();
      #1 rst_n = 1'b0;
      #1;
      exp = '0;
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL async_reset_mid: got %h expected %h", out_vec, exp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      exp = pack(1'b1, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd21);
      checks++;
      if (out_vec !== exp) begin
         failures++;
         $display("FAIL first_load_after_reset: got %h expected %h", out_vec, exp);
      end
   endtask

`ifdef MEM_WB_WB_MUX_EN
   task automatic test_wb_mux;
      drive(1'b1, 1'b0, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 5'd7);
      tick();
      checks++;
      if (wb_data_out !== 32'hA5A5_A5A5) begin
         failures++;
         $display("FAIL wb_mux_alu: got %h expected %h", wb_data_out, 32'hA5A5_A5A5);
      end
      MemtoReg_in = 1'b1;
      tick();
      checks++;
      if (wb_data_out !== 32'h5A5A_5A5A) begin
         failures++;
         $display("FAIL wb_mux_mem: got %h expected %h", wb_data_out, 32'h5A5A_5A5A);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (wb_data_out !== 32'h0) begin
         failures++;
         $display("FAIL wb_mux_flush: got %h expected %h", wb_data_out, 32'h0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_load();
      test_pipelining();
      test_stall();
      test_flush();
      test_async_reset_mid();
`ifdef MEM_WB_WB_MUX_EN
      test_wb_mux();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
